uart_rx: RTL and testbench
==========================

// Module: uart_rx
//
// PURPOSE
// - UART receiver: the stage directly downstream of uart_tx.
// - Samples the asynchronous serial line and reassembles frames (1 start bit, DATA_WIDTH data
//   bits LSB first, 1 stop bit, no parity) into parallel words.
// - Presents each word on a valid/ready handshake and flags framing errors and overruns.
// - Used in loopback with uart_tx and as the board-level receive path.
//
// PARAMETERS
// - DATA_WIDTH  8            data bits per frame
// - BAUD_RATE   9600         line rate, bits/s
// - CLK_FREQ    100_000_000  clk frequency, Hz
// - Derived: PULSE_WIDTH = CLK_FREQ/BAUD_RATE (10416 clk at defaults); HALF_PULSE = PULSE_WIDTH/2.
//
// PORTS
// - clk        in   1           system clock
// - rstn       in   1           reset, asynchronous assert, active-low
// - rx         in   1           serial line; asynchronous; idle high
// - data       out  DATA_WIDTH  received word; stable while valid=1
// - valid      out  1           word available
// - ready      in   1           consumer accepts; transfer on valid && ready at posedge clk
// - frame_err  out  1           one-cycle pulse: stop bit sampled 0
// - overrun    out  1           one-cycle pulse: frame completed while valid && !ready
// - busy       out  1           high in any state other than IDLE and WAIT_HIGH
//
// BEHAVIOUR
// Reset values
// - Reset is asynchronous and active-low: clock is clk, reset is rstn (low = reset).
// - Outputs in reset: data=0, valid=0, frame_err=0, overrun=0, busy=0.
// - 2-flop synchronizer resets to 1; FSM resets to WAIT_HIGH.
//
// Synchronizer and timing
// - rx passes through a 2-flop synchronizer; rx_s denotes the synchronized value.
// - All decisions use rx_s; 2-cycle input latency.
// - Bit counter cnt clears on every state entry and increments each clk.
//
// FSM
// - WAIT_HIGH: stay until rx_s==1, then -> IDLE. Prevents mid-frame lock-on after reset or
//   framing error.
// - IDLE: rx_s==0 -> START.
// - START: at cnt==HALF_PULSE-1 sample rx_s.
//   - 0: -> DATA, bit index=0.
//   - 1: glitch -> IDLE; no flags.
// - DATA: at cnt==PULSE_WIDTH-1 (mid-bit) shift rx_s into shift[DATA_WIDTH-1], right-shift.
//   After bit DATA_WIDTH-1 -> STOP.
// - STOP: at cnt==PULSE_WIDTH-1 sample rx_s.
//   - 1: frame good -> IDLE. Exits at mid stop bit, so back-to-back frames are caught.
//   - 0: frame_err=1 for one cycle, word discarded -> WAIT_HIGH.
//
// Output register on a good frame (same edge as stop sample)
// - valid==0, or valid && ready that cycle: data<=shift, valid<=1, overrun stays 0.
// - valid && !ready: new word dropped, data/valid unchanged, overrun=1 one cycle.
// - Otherwise valid clears on valid && ready.
//
// Output latency
// - valid rises at the mid-stop-bit sample plus 2 clk of synchronizer.
//
// Boundary conditions
// - rstn low mid-frame: immediate return to reset values.
// - After release, no frame accepted until the line has been seen high.
// - Counters sized $clog2(PULSE_WIDTH); no wrap inside a bit period.
//
// STRUCTURE
// - Package uart_pkg holds:
//   - typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP} uart_rx_state_e
//   - function pulse_width(clk_freq, baud)
// - Sub-module uart_sync2: 2-flop synchronizer, reset value parameter RST_VAL=1'b1.
// - FSM, counters, shift and output registers stay in uart_rx.
//
// TESTING (bench: uart_tx -> uart_rx loopback plus a direct line driver; default params)
// 1. Sweep data 0x00..0xFF via uart_tx, ready=1 -> each data equals sent word; exactly one
//    valid per frame; frame_err=0, overrun=0.
// 2. Drive rx low 2000 clk, then high -> no valid, no frame_err; busy returns 0 within
//    HALF_PULSE+3 clk.
// 3. Drive 0xA5 with stop bit 0 -> one-cycle frame_err, valid stays 0; line high then 0x3C
//    -> data=0x3C.
// 4. ready=0, send 0x11 then 0x22 -> data=0x11 held, valid=1; overrun pulse at 0x22 stop;
//    ready=1 -> valid drops next clk.
// 5. Assert rstn mid-bit 3 of 0x5A, release with line low -> no valid for that frame;
//    next 0x5A received correctly.
// 6. Pulse ready in the exact cycle the 0x77 stop bit is sampled while 0x66 is pending ->
//    no overrun, data=0x77, valid stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  // Receiver FSM states; WAIT_HIGH guards against locking on mid-frame.
  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_e;

  // Clocks per bit period.
  function automatic int pulse_width(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_reg;

  // Two back-to-back flops; both preset to the line's idle level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_reg <= RST_VAL;
      q        <= RST_VAL;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_WIDTH data bits LSB first, 1 stop, no parity.
// Words are presented on a valid/ready handshake; framing errors and overruns pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 9600,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int PULSE_WIDTH = pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int HALF_PULSE  = PULSE_WIDTH / 2;
  localparam int CW          = $clog2(PULSE_WIDTH);
  localparam int BW          = $clog2(DATA_WIDTH + 1);

  logic                  rx_s;
  uart_rx_state_e        state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [BW-1:0]         bit_reg, bit_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  valid_reg, valid_next;
  logic                  frame_err_reg, frame_err_next;
  logic                  overrun_reg, overrun_next;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx),
    .q    (rx_s)
  );

  // State, counters, shift and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= WAIT_HIGH;
      cnt_reg       <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  // Next-state, bit sampling and output-register update; cnt restarts on each new state or bit.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + CW'(1);
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    data_next      = data_reg;
    valid_next     = valid_reg && !ready;
    frame_err_next = 1'b0;
    overrun_next   = 1'b0;

    case (state_reg)
      WAIT_HIGH: begin
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (cnt_reg == CW'(HALF_PULSE - 1)) begin
          cnt_next   = '0;
          bit_next   = '0;
          // A line that is back high at mid-start was only a glitch.
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_reg == CW'(PULSE_WIDTH - 1)) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[DATA_WIDTH-1:1]};
          if (bit_reg == BW'(DATA_WIDTH - 1)) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + BW'(1);
          end
        end
      end
      STOP: begin
        if (cnt_reg == CW'(PULSE_WIDTH - 1)) begin
          cnt_next = '0;
          if (rx_s) begin
            // Leave at mid stop bit so an immediately following start edge is seen.
            state_next = IDLE;
            if (!valid_reg || ready) begin
              data_next  = shift_reg;
              valid_next = 1'b1;
            end else begin
              overrun_next = 1'b1;
            end
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_HIGH;
          end
        end
      end
      default: state_next = WAIT_HIGH;
    endcase
  end

  assign data      = data_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = (state_reg != IDLE) && (state_reg != WAIT_HIGH);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a scaled bit period (16 clk/bit) and a bench-side line driver.
module tb_uart_rx;

  localparam int DW     = 8;
  localparam int BAUD   = 10_000;
  localparam int CLK_HZ = 160_000;
  localparam int PW     = CLK_HZ / BAUD;
  localparam int HALF   = PW / 2;

  logic          clk   = 1'b0;
  logic          rstn  = 1'b0;
  logic          rx    = 1'b1;
  logic          ready = 1'b1;
  logic [DW-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] acc_q[$];
  int            ferr_cnt = 0;
  int            ovr_cnt  = 0;

  typedef struct {
    logic [7:0] tx;
    bit         stop;
    int         exp_words;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_WIDTH (DW),
    .BAUD_RATE  (BAUD),
    .CLK_FREQ   (CLK_HZ)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // Record accepted words and count pulse cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn && valid && ready) acc_q.push_back(data);
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame on the line, one bit per PW clocks, then return the line high.
  task automatic send_frame(input logic [7:0] b, input bit stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = f[i];
      repeat (PW - 1) @(negedge clk);
    end
    @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    int w0;
    int f0;
    int o0;
    int k;
    logic [9:0] fr;

    vecs[0] = '{8'hA5, 1'b0, 0, 8'h00, 1};
    vecs[1] = '{8'h3C, 1'b1, 1, 8'h3C, 0};
    vecs[2] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    vecs[4] = '{8'h80, 1'b1, 1, 8'h80, 0};
    vecs[5] = '{8'h01, 1'b1, 1, 8'h01, 0};

    // Reset values
    idle(3);
    check("reset data", int'(data), 0);
    check("reset valid", int'(valid), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset overrun", int'(overrun), 0);
    check("reset busy", int'(busy), 0);
    @(negedge clk);
    rstn = 1'b1;
    idle(4);

    // Table vectors: framing error on 0xA5, recovery with 0x3C, then edge patterns
    for (int i = 0; i < 6; i++) begin
      w0 = acc_q.size();
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      send_frame(vecs[i].tx, vecs[i].stop);
      idle(2 * PW);
      check($sformatf("vec%0d tx=%02h words", i, vecs[i].tx), acc_q.size() - w0, vecs[i].exp_words);
      check($sformatf("vec%0d tx=%02h frame_err cycles", i, vecs[i].tx), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d tx=%02h overrun cycles", i, vecs[i].tx), ovr_cnt - o0, 0);
      check($sformatf("vec%0d tx=%02h valid idle", i, vecs[i].tx), int'(valid), 0);
      if (vecs[i].exp_words == 1 && acc_q.size() > w0)
        check($sformatf("vec%0d tx=%02h data", i, vecs[i].tx), int'(acc_q[acc_q.size()-1]), int'(vecs[i].exp_data));
    end

    // Full byte sweep, back-to-back frames
    w0 = acc_q.size();
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1);
    idle(2 * PW);
    check("sweep word count", acc_q.size() - w0, 256);
    for (int b = 0; b < 256; b++) begin
      if (w0 + b < acc_q.size())
        check($sformatf("sweep word %02h", b), int'(acc_q[w0+b]), b);
    end
    check("sweep frame_err cycles", ferr_cnt - f0, 0);
    check("sweep overrun cycles", ovr_cnt - o0, 0);

    // Short low glitch: shorter than half a bit, must be rejected
    w0 = acc_q.size();
    f0 = ferr_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch busy raised", int'(busy), 1);
    rx = 1'b1;
    k = 0;
    while (busy && k < HALF + 3) begin
      @(negedge clk);
      k++;
    end
    check("glitch busy cleared in time", int'(busy), 0);
    idle(2 * PW);
    check("glitch words", acc_q.size() - w0, 0);
    check("glitch frame_err cycles", ferr_cnt - f0, 0);

    // Overrun: consumer stalled across two frames
    @(posedge clk);
    #1 ready = 1'b0;
    w0 = acc_q.size();
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(PW);
    check("stall valid held", int'(valid), 1);
    check("stall data held", int'(data), 8'h11);
    check("stall overrun cycles", ovr_cnt - o0, 1);
    check("stall nothing accepted", acc_q.size() - w0, 0);
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall valid drops after ready", int'(valid), 0);
    check("stall accepted count", acc_q.size() - w0, 1);
    if (acc_q.size() > w0) check("stall accepted word", int'(acc_q[acc_q.size()-1]), 8'h11);

    // Ready pulse lands exactly on the stop-sample edge of the next frame
    ready = 1'b0;
    send_frame(8'h66, 1'b1);
    idle(PW);
    check("pend 0x66 valid", int'(valid), 1);
    check("pend 0x66 data", int'(data), 8'h66);
    w0 = acc_q.size();
    o0 = ovr_cnt;
    fork
      send_frame(8'h77, 1'b1);
      begin
        @(negedge rx);
        repeat (154) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    idle(PW);
    check("edge-ready overrun cycles", ovr_cnt - o0, 0);
    check("edge-ready valid", int'(valid), 1);
    check("edge-ready data", int'(data), 8'h77);
    check("edge-ready accepted count", acc_q.size() - w0, 1);
    if (acc_q.size() > w0) check("edge-ready accepted word", int'(acc_q[acc_q.size()-1]), 8'h66);
    @(posedge clk);
    #1 ready = 1'b1;
    idle(4);
    check("drain 0x77", int'(acc_q[acc_q.size()-1]), 8'h77);

    // Reset mid bit 3 of 0x5A, released during bit 7 while the line is low
    w0 = acc_q.size();
    f0 = ferr_cnt;
    fr = {1'b1, 8'h5A, 1'b0};
    for (int c = 0; c < 10 * PW; c++) begin
      @(negedge clk);
      rx = fr[c/PW];
      if (c == 4 * PW + HALF) rstn = 1'b0;
      if (c == 4 * PW + HALF + 2) begin
        check("midframe reset data", int'(data), 0);
        check("midframe reset valid", int'(valid), 0);
        check("midframe reset busy", int'(busy), 0);
      end
      if (c == 8 * PW + HALF) rstn = 1'b1;
    end
    @(negedge clk);
    rx = 1'b1;
    idle(2 * PW);
    check("post-reset no word", acc_q.size() - w0, 0);
    check("post-reset frame_err cycles", ferr_cnt - f0, 0);
    w0 = acc_q.size();
    send_frame(8'h5A, 1'b1);
    idle(2 * PW);
    check("post-reset 0x5A count", acc_q.size() - w0, 1);
    if (acc_q.size() > w0) check("post-reset 0x5A data", int'(acc_q[acc_q.size()-1]), 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
